// File: rtl/demux_pkg.sv
// Shared constants for the burst dispatch controller and its counter.
// Optional feature macro used by the top level: DEMUX_BURST_STAT_EN.
package demux_pkg;

  localparam logic SEL_O0       = 1'b0;
  localparam logic SEL_O1       = 1'b1;
  localparam int   DEMUX_WIDTH  = 8;
  localparam int   DEMUX_STAT_W = 16;

  // Burst counter width: ceil(log2(burst)), but never less than one bit.
  function automatic int cnt_width(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage

// File: rtl/demux_burst_cnt.sv
// Burst position counter: decides the target output for the next accepted
// word and flags the accept that completes a burst.
module demux_burst_cnt
  import demux_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_accept,
  input  logic i_sync_clr,
  output logic o_tgt,
  output logic o_burst_done
);

  localparam int             CW   = cnt_width(BURST);
  localparam logic [CW-1:0]  LAST = CW'(BURST - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tgt;
  logic          w_last;

  assign w_last       = (r_cnt == LAST);
  assign o_tgt        = r_tgt;
  // Pulses with the accept itself; a clear in the same cycle does not hide it.
  assign o_burst_done = i_accept & w_last;

  // Count accepts; wrap and toggle target at burst end; clear wins over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_tgt <= SEL_O0;
    end else if (i_sync_clr) begin
      r_cnt <= '0;
      r_tgt <= SEL_O0;
    end else if (i_accept) begin
      if (w_last) begin
        r_cnt <= '0;
        r_tgt <= ~r_tgt;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/demux_burst_ctrl.sv
// Burst dispatch controller in front of a 1-to-2 demux. Holds one word and
// steers BURST consecutive words to o0, then BURST to o1, alternating.
// Optional macro DEMUX_BURST_STAT_EN adds per-output drain counters.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Upstream: in_valid/in_ready. Downstream: out_validN/out_readyN,
// where only the ready of the output selected by the held word matters.
// in_ready depends combinationally on out_ready so the register can be
// refilled in the same cycle it drains (full throughput).
module demux_burst_ctrl
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dmx_i,
  output logic             dmx_sel,
  output logic             out_valid0,
  output logic             out_valid1,
  input  logic             out_ready0,
  input  logic             out_ready1,
  output logic             burst_done
`ifdef DEMUX_BURST_STAT_EN
  ,
  output logic [DEMUX_STAT_W-1:0] stat_cnt0,
  output logic [DEMUX_STAT_W-1:0] stat_cnt1
`endif
);

  logic             r_vld;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  logic             w_drain;
  logic             w_accept;
  logic             w_tgt;

  assign w_drain    = r_vld & ((r_sel == SEL_O1) ? out_ready1 : out_ready0);
  assign in_ready   = ~r_vld | w_drain;
  assign w_accept   = in_valid & in_ready;
  assign out_valid0 = r_vld & (r_sel == SEL_O0);
  assign out_valid1 = r_vld & (r_sel == SEL_O1);
  assign dmx_sel    = r_sel;
  assign dmx_i      = r_vld ? r_data : '0;

  demux_burst_cnt #(
    .BURST (BURST)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_accept     (w_accept),
    .i_sync_clr   (sync_clr),
    .o_tgt        (w_tgt),
    .o_burst_done (burst_done)
  );

  // One-entry output register: load on accept, empty on drain-only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_sel  <= SEL_O0;
    end else if (w_accept) begin
      r_vld  <= 1'b1;
      r_data <= in_data;
      r_sel  <= w_tgt;
    end else if (w_drain) begin
      r_vld  <= 1'b0;
    end
  end

`ifdef DEMUX_BURST_STAT_EN
  logic [DEMUX_STAT_W-1:0] r_stat0;
  logic [DEMUX_STAT_W-1:0] r_stat1;

  assign stat_cnt0 = r_stat0;
  assign stat_cnt1 = r_stat1;

  // Count completed drains per output; free-running wrap, immune to sync_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else if (w_drain) begin
      if (r_sel == SEL_O1) r_stat1 <= r_stat1 + DEMUX_STAT_W'(1);
      else                 r_stat0 <= r_stat0 + DEMUX_STAT_W'(1);
    end
  end
`else
  // Drain statistics are not built in this configuration.
`endif

endmodule
